// File: rtl/stats_bank.sv
`default_nettype none
// ============================================================================
//  Module      : stats_bank
//  Description : Bank of NUM_CH wide event counters. Each channel adds a
//                per-cycle amount, can wrap or saturate, and flags overflow
//                in a sticky register. A 32-bit word read port returns low
//                and high counter halves; a low-word read snapshots the
//                upper half so a following high-word read is coherent.
//                A small control/status space provides freeze, clear_all
//                and write-1-to-clear overflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module stats_bank #(
    parameter int NUM_CH      = 8,   // 1..32 channels
    parameter int CNT_W       = 48,  // 32..64 counter bits
    parameter int AMT_W       = 8,   // 1..16 increment bits
    parameter int SATURATE    = 0,   // 1: stick at max, 0: wrap
    parameter int CLR_ON_READ = 0,   // 1: low-word read clears the counter
    parameter int ADDR_BITS   = 7    // 2**ADDR_BITS >= 2*NUM_CH+2
) (
    input  logic                    pcie_clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       inc_en,
    input  logic [NUM_CH*AMT_W-1:0] inc_amt,
    input  logic                    rd_en,
    input  logic [ADDR_BITS-1:0]    rd_addr,
    output logic [31:0]             rd_data,
    output logic                    rd_valid,
    input  logic                    wr_en,
    input  logic [ADDR_BITS-1:0]    wr_addr,
    input  logic [31:0]             wr_data
);

    // Channel index is the word address without its low/high select bit.
    localparam int                   CH_W      = ADDR_BITS - 1;
    localparam int                   SUM_W     = CNT_W + 1;
    localparam logic [ADDR_BITS-1:0] CTRL_ADDR = ADDR_BITS'(2 * NUM_CH);
    localparam logic [ADDR_BITS-1:0] OVF_ADDR  = ADDR_BITS'(2 * NUM_CH + 1);
    localparam logic [31:0]          UNMAPPED  = 32'hcafebabe;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_d;
    logic              freeze_q;
    logic              freeze_d;
    logic [31:0]       shadow_val_q;
    logic [31:0]       shadow_val_d;
    logic [CH_W-1:0]   shadow_tag_q;
    logic [CH_W-1:0]   shadow_tag_d;
    logic              shadow_vld_q;
    logic              shadow_vld_d;
    logic [31:0]       rd_data_q;
    logic [31:0]       rd_data_d;
    logic              rd_valid_q;
    logic              rd_valid_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [CH_W-1:0] rd_ch;
    logic            rd_is_cnt;
    logic            rd_lo;
    logic            rd_hi;
    logic            wr_ctrl;
    logic            wr_ovf;
    logic            clear_all;
    logic            shadow_hit;

    assign rd_ch      = rd_addr[ADDR_BITS-1:1];
    assign rd_is_cnt  = (rd_addr < CTRL_ADDR);
    assign rd_lo      = rd_en && rd_is_cnt && !rd_addr[0];
    assign rd_hi      = rd_en && rd_is_cnt &&  rd_addr[0];
    assign wr_ctrl    = wr_en && (wr_addr == CTRL_ADDR);
    assign wr_ovf     = wr_en && (wr_addr == OVF_ADDR);
    assign clear_all  = wr_ctrl && wr_data[0];
    assign shadow_hit = shadow_vld_q && (shadow_tag_q == rd_ch);

    // Every wr_data bit above the OVF flags is intentionally ignored.
    logic unused_wr_bits;
    assign unused_wr_bits = ^wr_data;

    // ------------------------------------------------------------------
    // Per-channel increment datapath
    // ------------------------------------------------------------------
    logic [AMT_W-1:0] ch_amt    [NUM_CH];
    logic [SUM_W-1:0] ch_sum    [NUM_CH];
    logic [NUM_CH-1:0] ch_active;
    logic [NUM_CH-1:0] ch_rd_clr;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_amt[gi]    = inc_amt[gi*AMT_W +: AMT_W];
        // Freeze masks increments but not clear_all or clear-on-read.
        assign ch_active[gi] = inc_en[gi] && !freeze_q;
        // One extra bit so the carry out marks an overflow.
        assign ch_sum[gi]    = {1'b0, cnt_q[gi]} + SUM_W'(ch_amt[gi]);
        assign ch_rd_clr[gi] = (CLR_ON_READ != 0) && rd_lo && (rd_ch == CH_W'(gi));
    end

    // Select the addressed counter, zero-extended to 64 bits so the upper
    // word is well defined for any CNT_W.
    logic [63:0] rd_cnt;

    // Read-side counter mux.
    always_comb begin
        rd_cnt = 64'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_cnt = 64'(cnt_q[i]);
            end
        end
    end

    // Next counter values and new overflow events; clear_all beats
    // clear-on-read, which beats a plain increment.
    logic [NUM_CH-1:0] ovf_set;

    always_comb begin
        ovf_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear_all) begin
                cnt_d[i] = '0;
            end else if (ch_rd_clr[i]) begin
                // Restart from this cycle's event so nothing is lost.
                cnt_d[i] = ch_active[i] ? CNT_W'(ch_amt[i]) : '0;
            end else if (ch_active[i]) begin
                if (ch_sum[i][CNT_W]) begin
                    ovf_set[i] = 1'b1;
                    cnt_d[i]   = (SATURATE != 0) ? '1 : ch_sum[i][CNT_W-1:0];
                end else begin
                    cnt_d[i]   = ch_sum[i][CNT_W-1:0];
                end
            end
        end
    end

    // Control/status next state: a new overflow wins over a same-cycle clear.
    always_comb begin
        ovf_d    = (ovf_q & ~(wr_ovf ? wr_data[NUM_CH-1:0] : {NUM_CH{1'b0}})) | ovf_set;
        freeze_d = wr_ctrl ? wr_data[1] : freeze_q;
    end

    // Shadow snapshot: low-word read captures, matching high-word read consumes.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_tag_d = shadow_tag_q;
        shadow_vld_d = shadow_vld_q;
        if (rd_lo) begin
            shadow_val_d = rd_cnt[63:32];
            shadow_tag_d = rd_ch;
            shadow_vld_d = 1'b1;
        end else if (rd_hi && shadow_hit) begin
            shadow_vld_d = 1'b0;
        end
    end

    // Read data mux; all sources are pre-update register values.
    logic [31:0] rd_word;

    always_comb begin
        rd_word = UNMAPPED;
        if (rd_is_cnt) begin
            if (!rd_addr[0]) begin
                rd_word = rd_cnt[31:0];
            end else if (shadow_hit) begin
                rd_word = shadow_val_q;
            end else begin
                rd_word = rd_cnt[63:32];
            end
        end else if (rd_addr == CTRL_ADDR) begin
            rd_word = {30'd0, freeze_q, 1'b0};
        end else if (rd_addr == OVF_ADDR) begin
            rd_word = 32'(ovf_q);
        end
        rd_data_d  = rd_en ? rd_word : rd_data_q;
        rd_valid_d = rd_en;
    end

    // All state registers, asynchronously cleared.
    always_ff @(posedge pcie_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q        <= '0;
            freeze_q     <= 1'b0;
            shadow_val_q <= 32'd0;
            shadow_tag_q <= '0;
            shadow_vld_q <= 1'b0;
            rd_data_q    <= 32'd0;
            rd_valid_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q        <= ovf_d;
            freeze_q     <= freeze_d;
            shadow_val_q <= shadow_val_d;
            shadow_tag_q <= shadow_tag_d;
            shadow_vld_q <= shadow_vld_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
`default_nettype wire
